// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-lane data memory for the MJ32 MEM stage.
//
// Supports byte, half and word loads and stores. Each store writes only the
// lanes it addresses. Loads are sign- or zero-extended.
//
// Request handshake (valid/ready):
//   - A request is accepted on a rising edge where req_v && req_rdy.
//   - req_rdy is 0 while the init sequence clears the array. After that it is
//     1 every cycle, so there is no backpressure.
//   - Every accepted request produces a one-cycle rsp_v pulse in the
//     following cycle.
//   - rsp_rdata and rsp_err hold their values while rsp_v is 0.
//
// After reset an init FSM writes INIT_VAL to every word, one word per cycle,
// before it accepts any request.
//
// Optional feature: define DMEM_STATS_EN to add the access counter acc_cnt
// and the saturating error counter err_cnt.
module dmem_bytelane #(
  parameter int          DEPTH    = 4096,
  parameter int          AW       = 32,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic          C,
  input  logic          Rn,
  input  logic          req_v,
  output logic          req_rdy,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_uns,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_v,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          dbg_state
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]   err_cnt,
  output logic [31:0]   acc_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-3:0] DEPTH_IDX = (AW-2)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [PW-1:0] ptr;

  logic [31:0] mem [DEPTH];

  logic [AW-3:0] word_idx;
  logic [PW-1:0] idx;
  logic [1:0]    ofs;
  logic          accept;
  logic          bad;
  logic          do_store;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd_word;
  logic [31:0]   sh;
  logic [31:0]   ld;

  assign word_idx  = req_addr[AW-1:2];
  assign idx       = word_idx[PW-1:0];
  assign ofs       = req_addr[1:0];
  assign accept    = req_v && req_rdy;
  assign do_store  = accept && req_we && !bad;
  assign dbg_state = state;

  // Error decode: illegal size, misaligned half or word, or word index out of range.
  always_comb begin
    bad = 1'b0;
    case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = ofs[0];
      2'b10:   bad = (ofs != 2'b00);
      default: bad = 1'b1;
    endcase
    if (word_idx >= DEPTH_IDX) bad = 1'b1;
  end

  // Lane enables, with the store data replicated so it lines up with every lane.
  always_comb begin
    be = 4'b0000;
    wd = 32'h0;
    case (req_size)
      2'b00: begin
        be = 4'b0001 << ofs;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << ofs;
        wd = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be = 4'b1111;
        wd = req_wdata;
      end
      default: begin
        be = 4'b0000;
        wd = 32'h0;
      end
    endcase
  end

  // Load path: shift the addressed lane down to bit 0, then extend it.
  always_comb begin
    rd_word = mem[idx];
    sh      = rd_word >> {ofs, 3'b000};
    ld      = 32'h0;
    case (req_size)
      2'b00:   ld = req_uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ld = req_uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      2'b10:   ld = rd_word;
      default: ld = 32'h0;
    endcase
  end

  // Init/run FSM. req_rdy is registered, so it rises on the edge that writes the last word.
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      state   <= S_INIT;
      ptr     <= '0;
      req_rdy <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (ptr == LAST_PTR) begin
            state   <= S_RUN;
            ptr     <= '0;
            req_rdy <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_RUN: begin
          req_rdy <= 1'b1;
        end
        default: begin
          state   <= S_INIT;
          ptr     <= '0;
          req_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: the init clear owns it in INIT, lane-masked stores own it in RUN.
  always_ff @(posedge C) begin
    if (state == S_INIT) begin
      mem[ptr] <= INIT_VAL;
    end else if (do_store) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wd[8*l +: 8];
      end
    end
  end

  // Registered response. Data and error update only when a request is accepted.
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      rsp_v     <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_v <= accept;
      if (accept) begin
        rsp_err   <= bad;
        rsp_rdata <= (bad || req_we) ? 32'h0 : ld;
      end
    end
  end

`ifdef DMEM_STATS_EN
  // Access and error counters. The error counter saturates.
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      acc_cnt <= 32'h0;
      err_cnt <= 16'h0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + 32'h1;
      if (bad && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'h1;
    end
  end
`endif

endmodule
